card_deal_controller: RTL and testbench

Sequences a new deal into the card memory when the game FSM enters its colour-computation phase. Builds N/2 colour pairs from a fixed palette and shuffles them with a free-running LFSR (Fisher-Yates). Writes every card slot's colour and initial state, then raises compute_done. Sits between the game FSM (compute_colors_en / compute_done) and the card memory write port; it is the sole writer to that port while busy.

---
 rtl/card_deal_controller_pkg.sv | 84 ++++++++
 rtl/card_deal_controller_lfsr16.sv | 34 +++
 rtl/card_deal_controller.sv | 189 ++++++++++++++++++
 tb/tb_card_deal_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/card_deal_controller_pkg.sv
// Shared card definitions: widths, card state codes, palette, write payload, shuffle helpers.
package card_deal_controller_pkg;

    localparam int unsigned MAX_CARDS = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned NUM_W     = 6;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned PAL_IDX_W = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

    typedef logic [1:0]         card_state_t;
    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam card_state_t CARD_UNUSED  = 2'b00;
    localparam card_state_t CARD_COVERED = 2'b01;
    localparam card_state_t CARD_REMOVED = 2'b10;
    localparam card_state_t CARD_SHOWN   = 2'b11;

    // One card-memory write beat
    typedef struct packed {
        logic        we;
        addr_t       addr;
        color_t      color;
        card_state_t state;
    } card_wr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_SHUFFLE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } deal_state_e;

    // Fixed RGB444 palette, one entry per colour pair
    function automatic color_t card_palette(input logic [PAL_IDX_W-1:0] idx);
        color_t c;
        case (idx)
            4'd0:    c = 12'hF00;
            4'd1:    c = 12'h0F0;
            4'd2:    c = 12'h00F;
            4'd3:    c = 12'hFF0;
            4'd4:    c = 12'hF0F;
            4'd5:    c = 12'h0FF;
            4'd6:    c = 12'hFFF;
            4'd7:    c = 12'hF80;
            4'd8:    c = 12'h8F0;
            4'd9:    c = 12'h08F;
            4'd10:   c = 12'hF08;
            4'd11:   c = 12'h80F;
            4'd12:   c = 12'h888;
            4'd13:   c = 12'hF88;
            4'd14:   c = 12'h8F8;
            default: c = 12'h88F;
        endcase
        return c;
    endfunction

    // Smallest all-ones value >= i, by smearing the top set bit downwards
    function automatic addr_t shuffle_mask(input addr_t i);
        addr_t m;
        m = i;
        for (int k = 1; k < int'(ADDR_W); k++) begin
            m = m | (i >> k);
        end
        return m;
    endfunction

    // Map masked random bits into 0..i; out-of-range values fold back below i
    function automatic addr_t fold_index(input addr_t r_raw, input addr_t i);
        addr_t r;
        r = r_raw & shuffle_mask(i);
        if (r <= i) begin
            return r;
        end
        return r - i - addr_t'(1);
    endfunction

endpackage

// File: rtl/card_deal_controller_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock.
module card_lfsr16
    import card_deal_controller_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Shift right, fold the feedback taps in when the outgoing bit is set
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // State register, reloads the seed on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/card_deal_controller.sv
// Builds a shuffled deal of colour pairs and streams it into the card memory.
module card_deal_controller
    import card_deal_controller_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compute_colors_en,
    input  logic [NUM_W-1:0]   num_of_cards,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_color,
    output logic [1:0]         mem_state,
    output logic               compute_done,
    output logic               busy,
    output logic               cfg_err
);

    deal_state_e       state_q, state_d;
    logic              en_q;
    logic [NUM_W-1:0]  neff_q, neff_d;
    addr_t             idx_q, idx_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    card_wr_t          wr_q, wr_d;
    color_t            card_buf_q [MAX_CARDS];
    color_t            card_buf_d [MAX_CARDS];

    logic [LFSR_W-1:0] lfsr_w;
    logic              lfsr_unused;
    logic              start_c;
    logic [NUM_W-1:0]  req_neff;
    logic              req_err;
    addr_t             swap_j;
    addr_t             last_idx;
    logic              idx_in_deck;

    card_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_w)
    );

    // Only the low bits feed the shuffle index
    assign lfsr_unused = ^lfsr_w[LFSR_W-1:ADDR_W];

    assign start_c     = (state_q == ST_IDLE) && compute_colors_en && !en_q;
    assign req_neff    = ((num_of_cards > NUM_W'(MAX_CARDS)) ? NUM_W'(MAX_CARDS) : num_of_cards)
                         & ~NUM_W'(1);
    assign req_err     = num_of_cards[0]
                         || (num_of_cards < NUM_W'(2))
                         || (num_of_cards > NUM_W'(MAX_CARDS));
    assign swap_j      = fold_index(lfsr_w[ADDR_W-1:0], idx_q);
    assign last_idx    = ADDR_W'(neff_q - NUM_W'(1));
    assign idx_in_deck = NUM_W'(idx_q) < neff_q;

    // Next-state, shuffle buffer update and registered output values
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        neff_d     = neff_q;
        cfg_err_d  = cfg_err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_d       = '0;
        card_buf_d = card_buf_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_c) begin
                    neff_d    = req_neff;
                    cfg_err_d = req_err;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = (req_neff == '0) ? ST_WRITE : ST_FILL;
                end
            end

            ST_FILL: begin
                if (!compute_colors_en) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    card_buf_d[idx_q] = card_palette(idx_q[ADDR_W-1:1]);
                    if (idx_q == last_idx) begin
                        state_d = ST_SHUFFLE;
                        idx_d   = last_idx;
                    end else begin
                        idx_d = idx_q + addr_t'(1);
                    end
                end
            end

            ST_SHUFFLE: begin
                if (!compute_colors_en) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    // j == i writes the same value back twice, i.e. no change
                    card_buf_d[idx_q]  = card_buf_q[swap_j];
                    card_buf_d[swap_j] = card_buf_q[idx_q];
                    if (idx_q == addr_t'(1)) begin
                        state_d = ST_WRITE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q - addr_t'(1);
                    end
                end
            end

            ST_WRITE: begin
                if (!compute_colors_en) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    wr_d.we    = 1'b1;
                    wr_d.addr  = idx_q;
                    wr_d.color = idx_in_deck ? card_buf_q[idx_q] : '0;
                    wr_d.state = idx_in_deck ? CARD_COVERED : CARD_UNUSED;
                    if (idx_q == addr_t'(MAX_CARDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + addr_t'(1);
                    end
                end
            end

            ST_DONE: begin
                busy_d = 1'b0;
                if (compute_colors_en) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // State, deck and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            neff_q    <= '0;
            idx_q     <= '0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= '0;
            for (int k = 0; k < int'(MAX_CARDS); k++) begin
                card_buf_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            en_q       <= compute_colors_en;
            neff_q     <= neff_d;
            idx_q      <= idx_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_q       <= wr_d;
            card_buf_q <= card_buf_d;
        end
    end

    assign mem_we       = wr_q.we;
    assign mem_addr     = wr_q.addr;
    assign mem_color    = wr_q.color;
    assign mem_state    = wr_q.state;
    assign compute_done = done_q;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_card_deal_controller.sv
// Self-checking bench for card_deal_controller: table deals, random deals, abort/reset/hold corners.
module tb_card_deal_controller;

    logic        clk;
    logic        rst;
    logic        en;
    logic [5:0]  num;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [11:0] mem_color;
    logic [1:0]  mem_state;
    logic        compute_done;
    logic        busy;
    logic        cfg_err;

    card_deal_controller dut (
        .clk               (clk),
        .rst               (rst),
        .compute_colors_en (en),
        .num_of_cards      (num),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_color         (mem_color),
        .mem_state         (mem_state),
        .compute_done      (compute_done),
        .busy              (busy),
        .cfg_err           (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; the DUT LFSR has stepped exactly this many times
    int ecount;
    always @(posedge clk or negedge rst) begin
        if (!rst) ecount <= 0;
        else      ecount <= ecount + 1;
    end

    int n_vec;
    int n_bad;
    int pal_tbl [16];
    int deck [32];

    typedef struct {
        int num;
        int neff;
        int err;
        int lat;
        int hold;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // LFSR value after k steps from the seed
    function automatic int lfsr_at(input int k);
        logic [15:0] v;
        v = 16'hACE1;
        for (int t = 0; t < k; t++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return int'(v);
    endfunction

    // Expected deck: pairs laid out in order, then Fisher-Yates with LFSR draws by cycle
    task automatic build_deck(input int neff, input int s);
        for (int a = 0; a < 32; a++) deck[a] = (a < neff) ? pal_tbl[a / 2] : 0;
        for (int i = neff - 1; i >= 1; i--) begin
            int m, r, j, tmp;
            m   = (1 << $clog2(i + 1)) - 1;
            r   = lfsr_at(s + 2 * neff - 1 - i) & m;
            j   = (r <= i) ? r : r - i - 1;
            tmp = deck[i];
            deck[i] = deck[j];
            deck[j] = tmp;
        end
    endtask

    task automatic run_deal(input int n, input int e_neff, input int e_err, input int e_lat,
                            input int hold);
        int s, lat, nw, hold_bad, bad;
        int ga [64];
        int gc [64];
        int gs [64];
        repeat ($urandom_range(1, 9)) @(negedge clk);
        num = 6'(n);
        en  = 1'b1;
        s   = ecount + 1;
        build_deck(e_neff, s);
        nw  = 0;
        lat = -1;
        for (int t = 0; t < 300 && lat < 0; t++) begin
            @(negedge clk);
            if (t == 0) num = 6'($urandom);
            if (mem_we) begin
                if (nw < 64) begin
                    ga[nw] = int'(mem_addr);
                    gc[nw] = int'(mem_color);
                    gs[nw] = int'(mem_state);
                end
                nw++;
            end
            if (compute_done) lat = ecount - s;
        end
        if (lat < 0) begin
            check("done_timeout", 0, 1);
            en = 1'b0;
            repeat (2) @(negedge clk);
            return;
        end
        check("latency", lat, e_lat);
        check("cfg_err", int'(cfg_err), e_err);
        check("busy_at_done", int'(busy), 0);
        check("write_count", nw, 32);
        for (int a = 0; a < 32 && a < nw; a++) begin
            check($sformatf("write[%0d] addr/state/colour", a),
                  (ga[a] << 14) | (gs[a] << 12) | gc[a],
                  (a << 14) | ((a < e_neff ? 1 : 0) << 12) | deck[a]);
        end
        bad = 0;
        for (int p = 0; p < e_neff / 2; p++) begin
            int cnt;
            cnt = 0;
            for (int a = 0; a < e_neff && a < nw; a++) if (gc[a] == pal_tbl[p]) cnt++;
            if (cnt != 2) bad++;
        end
        check("pair_multiset", bad, 0);
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!compute_done || mem_we) hold_bad++;
        end
        check("done_hold", hold_bad, 0);
        en = 1'b0;
        @(negedge clk);
        check("done_drop", int'(compute_done), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic abort_in_shuffle();
        int s, we_seen, done_seen;
        repeat ($urandom_range(1, 9)) @(negedge clk);
        num = 6'd16;
        en  = 1'b1;
        s   = ecount + 1;
        we_seen   = 0;
        done_seen = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (ecount - s == 10) check("busy_during_deal", int'(busy), 1);
            if (ecount - s == 19) en = 1'b0;
            if (mem_we) we_seen++;
            if (compute_done) done_seen++;
        end
        check("abort_no_write", we_seen, 0);
        check("abort_no_done", done_seen, 0);
        check("abort_busy", int'(busy), 0);
    endtask

    task automatic reset_mid_write();
        int found;
        repeat ($urandom_range(1, 9)) @(negedge clk);
        num   = 6'd16;
        en    = 1'b1;
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 5'd10) found = 1;
        end
        check("reach_addr10", found, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(compute_done), 0);
        check("rst_lfsr", int'(dut.u_lfsr.out), 'hACE1);
        en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        pal_tbl = '{'hF00, 'h0F0, 'h00F, 'hFF0, 'hF0F, 'h0FF, 'hFFF, 'hF80,
                    'h8F0, 'h08F, 'hF08, 'h80F, 'h888, 'hF88, 'h8F8, 'h88F};
        //         num neff err lat hold
        tbl[0] = '{16, 16, 0, 64, 100};
        tbl[1] = '{32, 32, 0, 96, 2};
        tbl[2] = '{32, 32, 0, 96, 0};
        tbl[3] = '{7,  6,  1, 44, 1};
        tbl[4] = '{40, 32, 1, 96, 0};
        tbl[5] = '{0,  0,  1, 33, 3};
        tbl[6] = '{2,  2,  0, 36, 0};
        tbl[7] = '{1,  0,  1, 33, 0};
        tbl[8] = '{63, 32, 1, 96, 1};
        tbl[9] = '{10, 10, 0, 52, 0};

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        en    = 1'b0;
        num   = '0;
        #12;
        check("reset_outputs",
              {mem_we, compute_done, busy, cfg_err, mem_state, mem_addr, mem_color}, 0);
        check("reset_lfsr", int'(dut.u_lfsr.out), 'hACE1);
        #10 rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_deal(tbl[v].num, tbl[v].neff, tbl[v].err, tbl[v].lat, tbl[v].hold);
        end

        abort_in_shuffle();
        run_deal(16, 16, 0, 64, 0);

        reset_mid_write();
        run_deal(16, 16, 0, 64, 0);

        for (int k = 0; k < 12; k++) begin
            int n, ne, er, la;
            n  = $urandom_range(0, 63);
            ne = ((n > 32) ? 32 : n) & ~1;
            er = ((n % 2) == 1 || n < 2 || n > 32) ? 1 : 0;
            la = (ne > 0) ? (2 * ne - 1 + 32 + 1) : 33;
            run_deal(n, ne, er, la, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
